// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: EX-stage resolution of fetch predictions; trains predictor, flushes and redirects on mispredict.
// Optional BRU_STATS_EN adds saturating branch/mispredict counters.
module branch_resolve_unit #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pred_valid,
    input  logic [31:0] pred_pc,
    input  logic        pred_dir,
    input  logic [31:0] pred_target,
    output logic        pred_ready,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic        upd_valid,
    output logic [31:0] upd_pc,
    output logic        upd_taken,
    output logic        flush_pipeline,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        order_err
`ifdef BRU_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t          state, state_nx;
    logic [FW-1:0]   fcnt, fcnt_nx;
    logic [31:0]     pc_q  [DEPTH];
    logic            dir_q [DEPTH];
    logic [31:0]     tgt_q [DEPTH];
    logic [AW-1:0]   head, tail;
    logic [CW-1:0]   count;
    logic            resolve, hit, p_dir, mispredict, push;
    logic [31:0]     p_tgt;

    assign pred_ready = (state == RUN) && (count != CW'(DEPTH));
    assign push       = pred_valid && pred_ready;
    assign resolve    = ex_valid && ex_is_branch && (state == RUN);
    assign hit        = resolve && (count != '0) && (pc_q[head] == ex_pc);
    // An unmatched resolve is treated as a not-taken prediction.
    assign p_dir      = hit && dir_q[head];
    assign p_tgt      = tgt_q[head];
    assign mispredict = resolve && ((p_dir != ex_taken) || (p_dir && ex_taken && p_tgt != ex_target));

    always_comb begin
        state_nx = state;
        fcnt_nx  = fcnt;
        if (mispredict) begin
            state_nx = FLUSH;
            fcnt_nx  = FW'(FLUSH_CYCLES - 1);
        end else if (state == FLUSH) begin
            state_nx = (fcnt == '0) ? RUN : FLUSH;
            fcnt_nx  = (fcnt == '0) ? fcnt : fcnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !mispredict) begin
            pc_q[tail]  <= pred_pc;
            dir_q[tail] <= pred_dir;
            tgt_q[tail] <= pred_target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= RUN;
            fcnt           <= '0;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            upd_valid      <= 1'b0;
            upd_pc         <= '0;
            upd_taken      <= 1'b0;
            flush_pipeline <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            order_err      <= 1'b0;
        end else begin
            state          <= state_nx;
            fcnt           <= fcnt_nx;
            upd_valid      <= resolve;
            flush_pipeline <= mispredict;
            redirect_valid <= mispredict;
            order_err      <= order_err || (resolve && !hit);
            if (resolve) begin
                upd_pc    <= ex_pc;
                upd_taken <= ex_taken;
            end
            if (mispredict) redirect_pc <= ex_taken ? ex_target : ex_pc + 32'd4;
            // Everything younger than a mispredicted branch is wrong-path.
            if (mispredict) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + 1'b1;
                if (hit) head <= head + 1'b1;
                count <= count + CW'(push) - CW'(hit);
            end
        end
    end

`ifdef BRU_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (resolve && !(&stat_branches)) stat_branches <= stat_branches + 1'b1;
            if (mispredict && !(&stat_mispredicts)) stat_mispredicts <= stat_mispredicts + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed plan plus random traffic against a queue-based reference model.
module tb_branch_resolve_unit;
    localparam int DEPTH = 4;
    localparam int FC    = 2;

    logic        clk = 1'b0, rst = 1'b0;
    logic        pred_valid, pred_dir, ex_valid, ex_is_branch, ex_taken;
    logic [31:0] pred_pc, pred_target, ex_pc, ex_target;
    logic        pred_ready, upd_valid, upd_taken, flush_pipeline, redirect_valid, order_err;
    logic [31:0] upd_pc, redirect_pc;
`ifdef BRU_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    branch_resolve_unit #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_dir(pred_dir), .pred_target(pred_target),
        .pred_ready(pred_ready),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .ex_target(ex_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .flush_pipeline(flush_pipeline), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .order_err(order_err)
`ifdef BRU_STATS_EN
        , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        dir;
        logic [31:0] tgt;
    } ent_t;

    ent_t        q[$];
    int          fl;
    logic        m_uv, m_ut, m_fl, m_rv, m_oe;
    logic [31:0] m_upc, m_rpc;
    int          nc = 0, nf = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nc++;
        assert (got === exp) else begin
            nf++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mreset();
        q.delete();
        fl = 0;
        {m_uv, m_ut, m_fl, m_rv, m_oe} = '0;
        m_upc = '0;
        m_rpc = '0;
    endtask

    function automatic bit m_ready();
        return fl == 0 && q.size() < DEPTH;
    endfunction

    task automatic idle();
        pred_valid = 0; pred_pc = 0; pred_dir = 0; pred_target = 0;
        ex_valid = 0; ex_is_branch = 0; ex_pc = 0; ex_taken = 0; ex_target = 0;
    endtask

    task automatic step();
        bit          res, push, hit, d, mis;
        logic [31:0] t;
        chk("pred_ready", pred_ready, m_ready());
        push = pred_valid && m_ready();
        res  = ex_valid && ex_is_branch && fl == 0;
        hit  = res && q.size() > 0 && q[0].pc == ex_pc;
        d    = hit ? q[0].dir : 1'b0;
        t    = hit ? q[0].tgt : 32'd0;
        mis  = res && (d != ex_taken || (d && ex_taken && t != ex_target));
        @(posedge clk);
        m_uv = res;
        if (res) begin
            m_upc = ex_pc;
            m_ut  = ex_taken;
        end
        m_fl = mis;
        m_rv = mis;
        if (mis) m_rpc = ex_taken ? ex_target : ex_pc + 32'd4;
        if (res && !hit) m_oe = 1;
        if (mis) begin
            q.delete();
            fl = FC;
        end else begin
            if (fl > 0) fl--;
            if (hit) void'(q.pop_front());
            if (push) q.push_back('{pred_pc, pred_dir, pred_target});
        end
        #1;
        chk("upd_valid", upd_valid, m_uv);
        chk("flush_pipeline", flush_pipeline, m_fl);
        chk("redirect_valid", redirect_valid, m_rv);
        chk("order_err", order_err, m_oe);
        if (m_uv) begin
            chk("upd_pc", upd_pc, m_upc);
            chk("upd_taken", upd_taken, m_ut);
        end
        if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
    endtask

    task automatic push1(input logic [31:0] pc, input logic dir, input logic [31:0] tgt);
        idle();
        pred_valid = 1; pred_pc = pc; pred_dir = dir; pred_target = tgt;
        step();
    endtask

    task automatic res1(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        idle();
        ex_valid = 1; ex_is_branch = 1; ex_pc = pc; ex_taken = tk; ex_target = tgt;
        step();
    endtask

    initial begin
        idle();
        mreset();
        #12;
        chk("rst_upd_valid", upd_valid, 0);
        chk("rst_flush", flush_pipeline, 0);
        chk("rst_order_err", order_err, 0);
        rst = 1;
        #2;
        // correct not-taken
        push1(32'h40, 0, 0);
        res1(32'h40, 0, 0);
        chk("t1_upd_pc", upd_pc, 32'h40);
        chk("t1_flush", flush_pipeline, 0);
        // direction mispredict; FLUSH keeps pred_ready low for two cycles
        push1(32'h80, 0, 0);
        push1(32'h84, 0, 0);
        res1(32'h80, 1, 32'h200);
        chk("t2_redirect_pc", redirect_pc, 32'h200);
        idle();
        step();
        chk("t2_ready_f1", pred_ready, 0);
        step();
        chk("t2_ready_run", pred_ready, 1);
        step();
        // target mispredict
        push1(32'h100, 1, 32'h300);
        res1(32'h100, 1, 32'h340);
        chk("t3_redirect_pc", redirect_pc, 32'h340);
        idle(); step(); step();
        // fall-through PC wraps
        push1(32'hFFFF_FFFC, 1, 32'h10);
        res1(32'hFFFF_FFFC, 0, 32'h10);
        chk("t4_redirect_pc", redirect_pc, 32'h0);
        idle(); step(); step();
        // fill, then simultaneous push and matching resolve while full
        for (int i = 0; i < DEPTH; i++) push1(32'h1000 + 32'(4 * i), 0, 0);
        chk("t5_full_ready", pred_ready, 0);
        idle();
        pred_valid = 1; pred_pc = 32'h2000;
        ex_valid = 1; ex_is_branch = 1; ex_pc = 32'h1000;
        step();
        chk("t5_ready_after_pop", pred_ready, 1);
        for (int i = 1; i < DEPTH; i++) res1(32'h1000 + 32'(4 * i), 0, 0);
        chk("t5_no_err", order_err, 0);
        // resolve on empty queue, then reset during FLUSH
        res1(32'h500, 1, 32'h600);
        chk("t6_order_err", order_err, 1);
        chk("t6_redirect_pc", redirect_pc, 32'h600);
        idle();
        step();
        #2;
        rst = 0;
        #1;
        mreset();
        chk("t6_rst_flush", flush_pipeline, 0);
        chk("t6_rst_rv", redirect_valid, 0);
        chk("t6_rst_rpc", redirect_pc, 0);
        chk("t6_rst_uv", upd_valid, 0);
        chk("t6_rst_upc", upd_pc, 0);
        chk("t6_rst_oe", order_err, 0);
        chk("t6_rst_ready", pred_ready, 1);
        #1;
        rst = 1;
        @(negedge clk);
        // random traffic
        for (int n = 0; n < 400; n++) begin
            pred_valid   = ($urandom % 2) == 1;
            pred_pc      = $urandom() & 32'hFFFF_FFFC;
            pred_dir     = ($urandom % 2) == 1;
            pred_target  = $urandom() & 32'hFFFF_FFFC;
            ex_valid     = ($urandom % 4) != 0;
            ex_is_branch = ($urandom % 3) != 0;
            ex_pc        = $urandom() & 32'hFFFF_FFFC;
            ex_taken     = ($urandom % 2) == 1;
            ex_target    = $urandom() & 32'hFFFF_FFFC;
            if (q.size() > 0 && ($urandom % 6) != 0) begin
                ex_pc = q[0].pc;
                if (($urandom % 10) < 7) ex_taken = q[0].dir;
                if (($urandom % 10) < 7) ex_target = q[0].tgt;
            end
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
        $finish;
    end
endmodule
